// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline-stage register with optional two-entry skid buffer
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous kill of every held entry
//   in_valid   upstream offers an entry
//   in_ready   stage accepts an entry this cycle
//   in_data    upstream datapath payload (DATA_W)
//   in_ctrl    upstream control payload (CTRL_W)
//   out_valid  out_data/out_ctrl hold a valid head entry
//   out_ready  downstream accepts the head this cycle
//   out_data   datapath payload of the head entry
//   out_ctrl   control payload of the head entry, CTRL_RST when out_valid=0
//   occupancy  number of held entries (0..2, 0..1 when SKID=0)
module pipe_stage_skid #(
  parameter int unsigned       DATA_W   = 101,
  parameter int unsigned       CTRL_W   = 11,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
  parameter int unsigned       SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Main register: always the head entry, drives the outputs directly.
  logic              mv_q, mv_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [1:0]        occ_q, occ_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = mv_q & out_ready;

  assign out_valid = mv_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv_q     <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= CTRL_RST;
      occ_q    <= 2'd0;
    end else begin
      mv_q     <= mv_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      occ_q    <= occ_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Skid register catches the entry accepted in the cycle the head
      // stalls; it is always younger than M, so sv implies mv.
      logic              sv_q, sv_d;
      logic [DATA_W-1:0] s_data_q, s_data_d;
      logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
      logic              rdy_q;

      // Registered ready: upstream timing never sees out_ready.
      assign in_ready = rdy_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sv_q     <= 1'b0;
          s_data_q <= '0;
          s_ctrl_q <= CTRL_RST;
          rdy_q    <= 1'b1;
        end else begin
          sv_q     <= sv_d;
          s_data_q <= s_data_d;
          s_ctrl_q <= s_ctrl_d;
          rdy_q    <= !sv_d;
        end
      end

      always_comb begin
        mv_d     = mv_q;
        sv_d     = sv_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
          // Data registers hold; only the valid bits and control are killed.
          mv_d     = 1'b0;
          sv_d     = 1'b0;
          m_ctrl_d = CTRL_RST;
          s_ctrl_d = CTRL_RST;
        end else if (!mv_q || out_fire) begin
          if (sv_q) begin
            // Head slot frees up: promote the skid entry.
            mv_d     = 1'b1;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            sv_d     = in_fire;
            if (in_fire) begin
              s_data_d = in_data;
              s_ctrl_d = in_ctrl;
            end else begin
              s_ctrl_d = CTRL_RST;
            end
          end else if (in_fire) begin
            mv_d     = 1'b1;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else begin
            mv_d     = 1'b0;
            m_ctrl_d = CTRL_RST;
          end
        end else if (in_fire) begin
          // Head stalled while upstream still pushed: park in skid.
          sv_d     = 1'b1;
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end
      end

      assign occ_d = {1'b0, mv_d} + {1'b0, sv_d};
    end else begin : g_single
      // Accept when empty or when the head leaves in the same cycle.
      assign in_ready = !mv_q | out_ready;

      always_comb begin
        mv_d     = mv_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        if (flush) begin
          mv_d     = 1'b0;
          m_ctrl_d = CTRL_RST;
        end else if (in_fire) begin
          mv_d     = 1'b1;
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (out_fire) begin
          mv_d     = 1'b0;
          m_ctrl_d = CTRL_RST;
        end
      end

      assign occ_d = {1'b0, mv_d};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid in both modes
module tb_pipe_stage_skid;

  localparam int DW = 101;
  localparam int CW = 11;
  localparam logic [CW-1:0] RST1 = '0;
  localparam logic [CW-1:0] RST0 = 11'h2A5;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready1, out_valid1;
  logic [DW-1:0] out_data1;
  logic [CW-1:0] out_ctrl1;
  logic [1:0]    occ1;

  logic          in_ready0, out_valid0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] out_ctrl0;
  logic [1:0]    occ0;

  ent_t q1[$];
  ent_t q0[$];
  int   compared = 0;
  int   failed   = 0;
  logic [127:0] rnd;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(RST1), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
    .occupancy(occ1)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(RST0), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
  endtask

  // Model view: a FIFO of capacity 2 (skid) or 1 (single); head is q[0].
  task automatic check_all();
    ent_t h;
    chk("s1_out_valid", 128'(out_valid1), 128'(q1.size() != 0));
    chk("s1_occupancy", 128'(occ1), 128'(q1.size()));
    chk("s1_in_ready", 128'(in_ready1), 128'(q1.size() < 2));
    if (q1.size() != 0) begin
      h = q1[0];
      chk("s1_out_data", 128'(out_data1), 128'(h.d));
      chk("s1_out_ctrl", 128'(out_ctrl1), 128'(h.c));
    end else begin
      chk("s1_ctrl_idle", 128'(out_ctrl1), 128'(RST1));
    end
    chk("s0_out_valid", 128'(out_valid0), 128'(q0.size() != 0));
    chk("s0_occupancy", 128'(occ0), 128'(q0.size()));
    chk("s0_in_ready", 128'(in_ready0), 128'((q0.size() == 0) || out_ready));
    if (q0.size() != 0) begin
      h = q0[0];
      chk("s0_out_data", 128'(out_data0), 128'(h.d));
      chk("s0_out_ctrl", 128'(out_ctrl0), 128'(h.c));
    end else begin
      chk("s0_ctrl_idle", 128'(out_ctrl0), 128'(RST0));
    end
  endtask

  task automatic tick();
    bit   if1, of1, if0, of0;
    ent_t e;
    #1;
    check_all();
    if1 = in_valid && (q1.size() < 2);
    of1 = out_ready && (q1.size() != 0);
    if0 = in_valid && ((q0.size() == 0) || out_ready);
    of0 = out_ready && (q0.size() != 0);
    e.d = in_data;
    e.c = in_ctrl;
    @(posedge clk);
    if (!rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (of1) void'(q1.pop_front());
      if (if1) q1.push_back(e);
      if (of0) void'(q0.pop_front());
      if (if0) q0.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, '0, '0, 0, 0);
    @(negedge clk);
    #1;
    chk("rst_s1_valid", 128'(out_valid1), 128'(0));
    chk("rst_s1_ctrl", 128'(out_ctrl1), 128'(RST1));
    chk("rst_s1_data", 128'(out_data1), 128'(0));
    chk("rst_s1_occ", 128'(occ1), 128'(0));
    chk("rst_s1_ready", 128'(in_ready1), 128'(1));
    chk("rst_s0_ctrl", 128'(out_ctrl0), 128'(RST0));
    chk("rst_s0_ready", 128'(in_ready0), 128'(1));
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back stream, out_ready held high.
    for (int i = 1; i <= 4; i++) begin
      drive(1, DW'(i), 11'h7FF, 1, 0);
      tick();
      chk("stream_data", 128'(out_data1), 128'(i));
      chk("stream_occ", 128'(occ1), 128'(1));
      chk("stream_ready", 128'(in_ready1), 128'(1));
    end
    drive(0, '0, '0, 1, 0);
    tick();
    tick();

    // Fill the skid buffer, then drain in order.
    drive(1, DW'('hA), 11'h123, 0, 0);
    tick();
    drive(1, DW'('hB), 11'h456, 0, 0);
    tick();
    chk("full_ready", 128'(in_ready1), 128'(0));
    chk("full_occ", 128'(occ1), 128'(2));
    chk("full_head", 128'(out_data1), 128'('hA));
    drive(0, '0, '0, 1, 0);
    tick();
    chk("drain_second", 128'(out_data1), 128'('hB));
    chk("drain_ready_back", 128'(in_ready1), 128'(1));
    tick();
    tick();

    // Flush a full stage while a new entry is offered.
    drive(1, DW'(1), 11'h011, 0, 0);
    tick();
    drive(1, DW'(2), 11'h022, 0, 0);
    tick();
    chk("pre_flush_occ", 128'(occ1), 128'(2));
    drive(1, DW'('hC), 11'h7FF, 0, 1);
    tick();
    chk("flush_s1_valid", 128'(out_valid1), 128'(0));
    chk("flush_s1_ctrl", 128'(out_ctrl1), 128'(RST1));
    chk("flush_s1_occ", 128'(occ1), 128'(0));
    chk("flush_s1_ready", 128'(in_ready1), 128'(1));
    chk("flush_s0_valid", 128'(out_valid0), 128'(0));
    chk("flush_s0_ctrl", 128'(out_ctrl0), 128'(RST0));
    drive(0, '0, '0, 1, 0);
    tick();
    tick();

    // Single-entry mode: ready follows out_ready once the head is held.
    for (int i = 0; i < 4; i++) begin
      drive(1, DW'('h20 + i), CW'('h100 + i), (i % 2) == 0, 0);
      if (i > 0) begin
        #1;
        chk("s0_ready_track", 128'(in_ready0), 128'(out_ready));
      end
      tick();
    end
    drive(0, '0, '0, 1, 0);
    tick();
    tick();

    // Asynchronous reset with the skid stage full.
    drive(1, DW'('h31), 11'h031, 0, 0);
    tick();
    drive(1, DW'('h32), 11'h032, 0, 0);
    tick();
    chk("pre_rst_occ", 128'(occ1), 128'(2));
    drive(0, '0, '0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_s1_valid", 128'(out_valid1), 128'(0));
    chk("arst_s1_occ", 128'(occ1), 128'(0));
    chk("arst_s1_ready", 128'(in_ready1), 128'(1));
    chk("arst_s1_ctrl", 128'(out_ctrl1), 128'(RST1));
    chk("arst_s1_data", 128'(out_data1), 128'(0));
    chk("arst_s0_valid", 128'(out_valid0), 128'(0));
    chk("arst_s0_ctrl", 128'(out_ctrl0), 128'(RST0));
    chk("arst_s0_data", 128'(out_data0), 128'(0));
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, DW'('h40 + i), CW'('h040 + i), 1, 0);
      tick();
    end
    drive(0, '0, '0, 1, 0);
    tick();
    tick();

    // Random valid/ready/flush traffic.
    for (int n = 0; n < 10000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 3) != 0, rnd[DW-1:0], CW'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      tick();
    end
    drive(0, '0, '0, 1, 0);
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
